// File: rtl/audio_pkg.sv
// Shared register map, status/control bit positions and status packing helper
// for the audio sample reader. Optional threshold/irq feature: AUDIO_RD_IRQ_EN.
package audio_pkg;

  localparam int REG_W = 32;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_CTRL   = 3'd2;
  localparam logic [2:0] ADDR_THRESH = 3'd3;

  localparam int STAT_EMPTY = 16;
  localparam int STAT_FULL  = 17;
  localparam int STAT_OVF   = 18;
  localparam int STAT_UNF   = 19;

  localparam int CTRL_FLUSH   = 0;
  localparam int CTRL_CLR_OVF = 1;
  localparam int CTRL_CLR_UNF = 2;

  typedef struct packed {
    logic ovf;
    logic unf;
  } sticky_t;

  function automatic logic [REG_W-1:0] status_word(input logic [15:0] count,
                                                   input logic empty,
                                                   input logic full,
                                                   input sticky_t flags);
    logic [REG_W-1:0] w;
    w             = '0;
    w[15:0]       = count;
    w[STAT_EMPTY] = empty;
    w[STAT_FULL]  = full;
    w[STAT_OVF]   = flags.ovf;
    w[STAT_UNF]   = flags.unf;
    return w;
  endfunction

endpackage

// File: rtl/audio_sample_reader_if.sv
// Avalon-MM slave bus bundle for the audio sample reader register window.
interface audio_sample_reader_if;

  logic        chipselect;
  logic        read;
  logic        write;
  logic [2:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output chipselect, read, write, address, writedata,
    input  readdata
  );

  modport slave (
    input  chipselect, read, write, address, writedata,
    output readdata
  );

endinterface

// File: rtl/audio_sync_fifo.sv
// Single-clock sample FIFO: storage array, wrapping pointers, occupancy count.
// push_i/pop_i arrive already qualified against full/empty by the caller.
module audio_sync_fifo #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [CNT_W-1:0]  count_o,
  output logic [CNT_W-1:0]  count_next_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Power-of-two depth lets the pointers wrap by natural overflow.
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o    = mem[rd_ptr_q];
  assign count_o      = count_q;
  assign count_next_o = count_d;
  assign full_o       = (count_q == CNT_W'(DEPTH));
  assign empty_o      = (count_q == '0);

endmodule

// File: rtl/audio_sample_reader.sv
// Audio sample reader: codec samples queued in a FIFO and drained over Avalon-MM.
// Define AUDIO_RD_IRQ_EN to add the threshold register (address 3) and irq output.
module audio_sample_reader
  import audio_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              sample_valid,
  audio_sample_reader_if.slave avs
`ifdef AUDIO_RD_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  fifo_count_next;
  logic              fifo_full;
  logic              fifo_empty;

  logic rd_data_req;
  logic wr_ctrl;
  logic flush;
  logic pop;
  logic push;

  sticky_t            sticky_q, sticky_d;
  logic [REG_W-1:0]   readdata_q, readdata_d;

  assign rd_data_req = avs.chipselect && avs.read  && (avs.address == ADDR_DATA);
  assign wr_ctrl     = avs.chipselect && avs.write && (avs.address == ADDR_CTRL);
  assign flush       = wr_ctrl && avs.writedata[CTRL_FLUSH];
  assign pop         = rd_data_req && !fifo_empty;
  // A full FIFO still accepts a sample when the same cycle frees a slot.
  assign push        = sample_valid && (!fifo_full || pop) && !flush;

  audio_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk          (clk),
    .reset_n      (reset_n),
    .push_i       (push),
    .pop_i        (pop),
    .flush_i      (flush),
    .wr_data_i    (sample_data),
    .rd_data_o    (fifo_head),
    .count_o      (fifo_count),
    .count_next_o (fifo_count_next),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty)
  );

  // Set terms are OR-ed after the clear so a coincident set wins.
  always_comb begin
    sticky_d     = sticky_q;
    sticky_d.ovf = (sticky_q.ovf && !(wr_ctrl && avs.writedata[CTRL_CLR_OVF]))
                   || (sample_valid && fifo_full && !pop);
    sticky_d.unf = (sticky_q.unf && !(wr_ctrl && avs.writedata[CTRL_CLR_UNF]))
                   || (rd_data_req && fifo_empty);
  end

`ifdef AUDIO_RD_IRQ_EN
  logic [15:0] threshold_q, threshold_d;
  logic        irq_q, irq_d;

  always_comb begin
    threshold_d = threshold_q;
    if (avs.chipselect && avs.write && (avs.address == ADDR_THRESH))
      threshold_d = avs.writedata[15:0];
    irq_d = (threshold_d != 16'd0) && (16'(fifo_count_next) >= threshold_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      threshold_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      threshold_q <= threshold_d;
      irq_q       <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  logic unused_count_next;
  assign unused_count_next = ^fifo_count_next;
`endif

  always_comb begin
    readdata_d = readdata_q;
    if (avs.chipselect && avs.read) begin
      case (avs.address)
        ADDR_DATA:   readdata_d = fifo_empty ? '0 : REG_W'(fifo_head);
        ADDR_STATUS: readdata_d = status_word(16'(fifo_count), fifo_empty,
                                              fifo_full, sticky_q);
`ifdef AUDIO_RD_IRQ_EN
        ADDR_THRESH: readdata_d = {16'd0, threshold_q};
`endif
        default:     readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sticky_q   <= '0;
      readdata_q <= '0;
    end else begin
      sticky_q   <= sticky_d;
      readdata_q <= readdata_d;
    end
  end

  assign avs.readdata = readdata_q;

endmodule

// File: tb/tb_audio_sample_reader.sv
// Directed bench for audio_sample_reader: vector table plus hand-written
// overflow, full push/pop, reset-abort and (optionally) irq sequences.
module tb_audio_sample_reader;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 32;

  logic              clk;
  logic              reset_n;
  logic [DATA_W-1:0] sample_data;
  logic              sample_valid;
`ifdef AUDIO_RD_IRQ_EN
  logic              irq;
`endif

  audio_sample_reader_if bus ();

  audio_sample_reader #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .avs          (bus)
`ifdef AUDIO_RD_IRQ_EN
    ,
    .irq          (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        sv;
    logic [31:0] sd;
    logic        rd;
    logic        wr;
    logic [2:0]  a;
    logic [31:0] wd;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic sv, input logic [31:0] sd,
                              input logic rd, input logic wr,
                              input logic [2:0] a, input logic [31:0] wd,
                              input logic chk, input logic [31:0] exp);
    vec_t v;
    v.sv = sv; v.sd = sd; v.rd = rd; v.wr = wr;
    v.a = a; v.wd = wd; v.chk = chk; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  task automatic idle();
    sample_valid  = 1'b0;
    sample_data   = '0;
    bus.chipselect = 1'b0;
    bus.read      = 1'b0;
    bus.write     = 1'b0;
    bus.address   = '0;
    bus.writedata = '0;
  endtask

  task automatic step(input logic sv, input logic [31:0] sd, input logic rd,
                      input logic wr, input logic [2:0] a, input logic [31:0] wd);
    sample_valid   = sv;
    sample_data    = sd;
    bus.chipselect = rd | wr;
    bus.read       = rd;
    bus.write      = wr;
    bus.address    = a;
    bus.writedata  = wd;
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic push(input logic [31:0] d);
    step(1'b1, d, 1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic rd(input logic [2:0] a);
    step(1'b0, 32'd0, 1'b1, 1'b0, a, 32'd0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    step(1'b0, 32'd0, 1'b0, 1'b1, a, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_readdata", bus.readdata, 32'h0);
`ifdef AUDIO_RD_IRQ_EN
    check("reset_irq", {31'd0, irq}, 32'h0);
`endif
    reset_n = 1'b1;

    // sv, sd, rd, wr, addr, wdata, chk, expected readdata after the edge
    tv.push_back(mk(0, 32'h0,  1, 0, 3'd1, 32'h0, 1, 32'h0001_0000));
    tv.push_back(mk(1, 32'h11, 0, 0, 3'd0, 32'h0, 0, 32'h0));
    tv.push_back(mk(1, 32'h22, 0, 0, 3'd0, 32'h0, 0, 32'h0));
    tv.push_back(mk(1, 32'h33, 0, 0, 3'd0, 32'h0, 0, 32'h0));
    tv.push_back(mk(0, 32'h0,  1, 0, 3'd1, 32'h0, 1, 32'h0000_0003));
    tv.push_back(mk(0, 32'h0,  1, 0, 3'd0, 32'h0, 1, 32'h11));
    tv.push_back(mk(0, 32'h0,  1, 0, 3'd0, 32'h0, 1, 32'h22));
    tv.push_back(mk(0, 32'h0,  1, 0, 3'd0, 32'h0, 1, 32'h33));
    tv.push_back(mk(0, 32'h0,  1, 0, 3'd1, 32'h0, 1, 32'h0001_0000));
    tv.push_back(mk(0, 32'h0,  1, 0, 3'd0, 32'h0, 1, 32'h0));
    tv.push_back(mk(0, 32'h0,  1, 0, 3'd1, 32'h0, 1, 32'h0009_0000));
    tv.push_back(mk(0, 32'h0,  0, 1, 3'd2, 32'h4, 1, 32'h0009_0000));
    tv.push_back(mk(0, 32'h0,  1, 0, 3'd1, 32'h0, 1, 32'h0001_0000));
    tv.push_back(mk(0, 32'h0,  1, 0, 3'd3, 32'h0, 1, 32'h0));
    tv.push_back(mk(1, 32'hAB, 1, 0, 3'd1, 32'h0, 1, 32'h0001_0000));
    tv.push_back(mk(0, 32'h0,  1, 0, 3'd7, 32'h0, 1, 32'h0));
    tv.push_back(mk(0, 32'h0,  0, 1, 3'd7, 32'hFFFF_FFFF, 1, 32'h0));
    tv.push_back(mk(0, 32'h0,  1, 0, 3'd1, 32'h0, 1, 32'h0000_0001));
    tv.push_back(mk(1, 32'hCD, 1, 0, 3'd0, 32'h0, 1, 32'hAB));
    tv.push_back(mk(0, 32'h0,  1, 0, 3'd0, 32'h0, 1, 32'hCD));
    tv.push_back(mk(1, 32'hEE, 1, 0, 3'd0, 32'h0, 1, 32'h0));
    tv.push_back(mk(0, 32'h0,  1, 0, 3'd1, 32'h0, 1, 32'h0008_0001));
    tv.push_back(mk(1, 32'h99, 0, 1, 3'd2, 32'h1, 1, 32'h0008_0001));
    tv.push_back(mk(0, 32'h0,  1, 0, 3'd1, 32'h0, 1, 32'h0009_0000));
    tv.push_back(mk(0, 32'h0,  0, 1, 3'd2, 32'h4, 0, 32'h0));
    tv.push_back(mk(0, 32'h0,  1, 0, 3'd1, 32'h0, 1, 32'h0001_0000));

    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].sv, tv[i].sd, tv[i].rd, tv[i].wr, tv[i].a, tv[i].wd);
      if (tv[i].chk) check($sformatf("vec%0d", i), bus.readdata, tv[i].exp);
    end

    // Overflow: DEPTH+1 pushes, the last one is dropped.
    for (int i = 0; i <= DEPTH; i++) push(32'h100 + i);
    rd(3'd1);
    check("ovf_status", bus.readdata, 32'h0006_0010);
    step(1'b1, 32'h200, 1'b0, 1'b1, 3'd2, 32'h2);
    rd(3'd1);
    check("ovf_set_wins", bus.readdata, 32'h0006_0010);
    wr(3'd2, 32'h2);
    rd(3'd1);
    check("ovf_cleared", bus.readdata, 32'h0002_0010);

    // Full FIFO with same-cycle push and pop.
    step(1'b1, 32'h1FF, 1'b1, 1'b0, 3'd0, 32'h0);
    check("full_pushpop_head", bus.readdata, 32'h100);
    rd(3'd1);
    check("full_pushpop_status", bus.readdata, 32'h0002_0010);
    for (int i = 1; i < DEPTH; i++) begin
      rd(3'd0);
      check($sformatf("drain%0d", i), bus.readdata, 32'h100 + i);
    end
    rd(3'd0);
    check("drain_last", bus.readdata, 32'h1FF);
    rd(3'd1);
    check("drain_status", bus.readdata, 32'h0001_0000);

    // Reset mid-fill with a read in flight.
    for (int i = 0; i < 10; i++) push(32'h300 + i);
    rd(3'd1);
    check("midfill_count", bus.readdata, 32'h0000_000A);
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.address    = 3'd0;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_readdata", bus.readdata, 32'h0);
    idle();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("post_reset_readdata", bus.readdata, 32'h0);
    rd(3'd1);
    check("post_reset_status", bus.readdata, 32'h0001_0000);

`ifdef AUDIO_RD_IRQ_EN
    wr(3'd3, 32'h4);
    rd(3'd3);
    check("thresh_rb", bus.readdata, 32'h4);
    for (int i = 0; i < 3; i++) push(32'h400 + i);
    check("irq_below", {31'd0, irq}, 32'h0);
    push(32'h403);
    check("irq_at_thresh", {31'd0, irq}, 32'h1);
    rd(3'd0);
    check("irq_pop_data", bus.readdata, 32'h400);
    check("irq_after_pop", {31'd0, irq}, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
